regfile_context_engine: RTL



---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_context_engine.sv | 113 +++++++++++
 2 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file context engine.
// Holds the register-file geometry and the engine's FSM state encoding.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;
endpackage

// File: rtl/regfile_context_engine.sv
// Register-file context engine.
// Save streams registers FIRST_REG..LAST_REG out of read port 1.
// Restore writes an incoming stream back into the same register range.
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   start_save/start_restore/abort  control; starts are sampled in IDLE only
//   busy, done      status; done is a one-cycle completion pulse
//   rf_read_reg/rf_read_data        register-file read port 1 (combinational read)
//   rf_reg_write/rf_write_reg/rf_write_data  register-file write port
//   out_valid/out_ready/out_data/out_idx     save stream
//   in_valid/in_ready/in_data                restore stream
// All outputs decode from the current state, so they fall to zero together
// with an asynchronous reset.
module regfile_context_engine #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_save,
  input  logic              start_restore,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_read_reg,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data
);
  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    busy          = 1'b0;
    done          = 1'b0;
    rf_read_reg   = '0;
    rf_reg_write  = 1'b0;
    rf_write_reg  = '0;
    rf_write_data = '0;
    out_valid     = 1'b0;
    out_data      = '0;
    out_idx       = '0;
    in_ready      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = FIRST_IDX;
        if (start_save)         state_d = ST_SAVE;
        else if (start_restore) state_d = ST_RESTORE;
      end
      ST_SAVE: begin
        busy        = 1'b1;
        rf_read_reg = idx_q;
        out_idx     = idx_q;
        out_data    = rf_read_data;
        out_valid   = 1'b1;
        if (abort)                 state_d = ST_IDLE;
        else if (out_ready) begin
          if (idx_q == LAST_IDX)   state_d = ST_DONE;
          else                     idx_d   = idx_q + 1'b1;
        end
      end
      ST_RESTORE: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        // The write is combinational with the handshake, so a beat accepted
        // alongside abort still lands in the register file.
        if (in_valid) begin
          rf_reg_write  = 1'b1;
          rf_write_reg  = idx_q;
          rf_write_data = in_data;
        end
        if (abort)                 state_d = ST_IDLE;
        else if (in_valid) begin
          if (idx_q == LAST_IDX)   state_d = ST_DONE;
          else                     idx_d   = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= FIRST_IDX;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end
endmodule
